cond_write_back_arbiter: RTL and testbench
==========================================

COND_WRITE_BACK_ARBITER -- requirements
Module: cond_write_back_arbiter

Interface
REQ-001 Parameter ARBITER_DEPTH, default 4, SHALL set the number of requesting execution units (legal range 1..16).
REQ-002 Parameter RS_ID_WIDTH, default 5, SHALL set the reservation station ID width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 input_valid  input  [0:ARBITER_DEPTH-1] x 1  SHALL carry the per-unit condition result valid.
REQ-006 input_ready  output  [0:ARBITER_DEPTH-1] x 1  SHALL carry the per-unit accept.
REQ-007 rs_id_in  input  [0:ARBITER_DEPTH-1] x RS_ID_WIDTH  SHALL carry the producing RS ID.
REQ-008 cr0_xer_in  input  [0:ARBITER_DEPTH-1] x cond_exception_t  SHALL carry CR0 bits (LT, GT, EQ, SO), XER bits (SO, OV, CA) and the alter flags alter_CR0, alter_CA, alter_OV.
REQ-009 output_valid  output  1  SHALL indicate a registered result is held.
REQ-010 output_ready  input  1  SHALL be the downstream (CR/XER register files) accept.
REQ-011 rs_id_out  output  RS_ID_WIDTH  SHALL carry the held RS ID.
REQ-012 cr0_xer_out  output  cond_exception_t  SHALL carry the held condition result.
REQ-013 cr0_write_enable  output  1  SHALL strobe a CR field 0 write.
REQ-014 xer_write_enable  output  1  SHALL strobe an XER write.

Function
REQ-015 One output register stage; advance = !output_valid | output_ready.
REQ-016 Round-robin pointer prio (clog2(ARBITER_DEPTH) bits); grant g SHALL be the first index with input_valid set, searching prio, prio+1, ... with wrap from ARBITER_DEPTH-1 to 0.
REQ-017 input_ready[g] SHALL be 1 only when advance and a grant exists; all other input_ready bits 0; at most one bit set per cycle.
REQ-018 input_ready SHALL depend on input_valid; requesters SHALL NOT make input_valid depend on input_ready.
REQ-019 Accept (input_valid[g] & input_ready[g]) with any alter flag set: rs_id_out, cr0_xer_out loaded; output_valid <= 1 next cycle (latency 1).
REQ-020 Accept with all three alter flags clear: entry consumed and discarded; output_valid <= 0 if advancing.
REQ-021 Every accept SHALL set prio <= (g+1) mod ARBITER_DEPTH; no accept leaves prio unchanged.
REQ-022 Advance without any valid input SHALL clear output_valid; held data may remain but is don't-care.
REQ-023 output_valid & !output_ready: output registers and prio SHALL hold; all input_ready 0.
REQ-024 Throughput SHALL be one accept per cycle while output_ready stays 1.
REQ-025 A continuously valid requester SHALL be accepted within ARBITER_DEPTH accepts (no starvation).
REQ-026 cr0_write_enable = output_valid & output_ready & alter_CR0 of held result; xer_write_enable = output_valid & output_ready & (alter_CA | alter_OV); combinational from registers.
REQ-027 ARBITER_DEPTH=1: prio constant 0, behaviour otherwise identical.

Reset
REQ-028 While rst=0: output_valid 0, rs_id_out 0, cr0_xer_out all-zero, prio 0, all input_ready 0, both write enables 0.
REQ-029 Reset asserted mid-transfer SHALL discard the held result without generating a write enable.
REQ-030 First accept is possible in the first clock after rst deassertion.

Structure
REQ-031 cond_exception_t SHALL remain defined in ppc_types; no new package types needed.
REQ-032 Pointer width SHALL be a localparam derived via $clog2 inside the module.
REQ-033 Wrap-around first-valid search SHALL be a combinational sub-module round_robin_select (inputs request vector, prio; outputs grant index, grant_valid).

Verification
REQ-034 DEPTH=4, all four valid continuously, output_ready=1, alter_CR0=1 -> accepts in order 0,1,2,3,0; one output_valid per cycle; cr0_write_enable every cycle.
REQ-035 Unit 2 valid with rs_id 5'd9, alter_CA=1, CA=1 -> next cycle output_valid=1, rs_id_out=9, xer_write_enable=1, cr0_write_enable=0.
REQ-036 Output held, output_ready=0 for 3 cycles with units 1 and 3 valid -> all input_ready 0, outputs stable; on release unit (prio) accepted.
REQ-037 Unit 0 valid with all alter flags clear -> input_ready[0]=1, next cycle output_valid=0, prio=1.
REQ-038 prio=3, units 0 and 3 valid -> unit 3 granted, prio wraps to 0, then unit 0 granted.
REQ-039 rst pulled low while output_valid=1 -> output_valid 0 immediately (asynchronously), no write enable, prio=0 after release.

Source files
------------

// File: rtl/ppc_types.sv
// Shared PowerPC datapath types: condition-register field 0 / XER result with
// the flags that say which of them an instruction actually alters.
package ppc_types;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic so;
    logic xer_so;
    logic ov;
    logic ca;
    logic alter_cr0;
    logic alter_ca;
    logic alter_ov;
  } cond_exception_t;

endpackage

// File: rtl/round_robin_select.sv
// Wrap-around first-set search over a request vector, starting at prio.
module round_robin_select #(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic [0:DEPTH-1] req,
  input  logic [PW-1:0]    prio,
  output logic [PW-1:0]    grant,
  output logic             grant_valid
);

  // Scan farthest offset first so the nearest valid requester wins last.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = (int'(prio) + i) % DEPTH;
      if (req[idx]) begin
        grant       = PW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cond_write_back_arbiter.sv
// Round-robin arbiter collecting CR0/XER condition results from execution
// units into one registered write-back slot for the CR/XER register files.
module cond_write_back_arbiter
  import ppc_types::*;
#(
  parameter int ARBITER_DEPTH = 4,
  parameter int RS_ID_WIDTH   = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [0:ARBITER_DEPTH-1]            input_valid,
  output logic [0:ARBITER_DEPTH-1]            input_ready,
  input  logic [0:ARBITER_DEPTH-1][RS_ID_WIDTH-1:0] rs_id_in,
  input  cond_exception_t [0:ARBITER_DEPTH-1] cr0_xer_in,
  output logic                                output_valid,
  input  logic                                output_ready,
  output logic [RS_ID_WIDTH-1:0]              rs_id_out,
  output cond_exception_t                     cr0_xer_out,
  output logic                                cr0_write_enable,
  output logic                                xer_write_enable
);

  localparam int PW = (ARBITER_DEPTH > 1) ? $clog2(ARBITER_DEPTH) : 1;

  logic [PW-1:0]   prio;
  logic [PW-1:0]   prio_nxt;
  logic [PW-1:0]   grant;
  logic            grant_valid;
  logic            advance;
  logic            accept;
  logic            alter_any;
  cond_exception_t sel_cx;

  round_robin_select #(
    .DEPTH (ARBITER_DEPTH),
    .PW    (PW)
  ) u_sel (
    .req         (input_valid),
    .prio        (prio),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign advance   = !output_valid || output_ready;
  // Gated by rst so no requester sees an accept while the block is held in reset.
  assign accept    = advance && grant_valid && rst;
  assign sel_cx    = cr0_xer_in[grant];
  assign alter_any = sel_cx.alter_cr0 || sel_cx.alter_ca || sel_cx.alter_ov;

  always_comb begin
    input_ready = '0;
    if (accept) input_ready[grant] = 1'b1;
  end

  always_comb begin
    prio_nxt = '0;
    if (ARBITER_DEPTH > 1 && grant != PW'(ARBITER_DEPTH - 1)) prio_nxt = grant + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_valid <= 1'b0;
      rs_id_out    <= '0;
      cr0_xer_out  <= '0;
      prio         <= '0;
    end else if (advance) begin
      // Results that alter nothing are consumed here and never reach the slot.
      output_valid <= accept && alter_any;
      if (accept) begin
        prio <= prio_nxt;
        if (alter_any) begin
          rs_id_out   <= rs_id_in[grant];
          cr0_xer_out <= sel_cx;
        end
      end
    end
  end

  assign cr0_write_enable = output_valid && output_ready && cr0_xer_out.alter_cr0;
  assign xer_write_enable = output_valid && output_ready &&
                            (cr0_xer_out.alter_ca || cr0_xer_out.alter_ov);

endmodule

// File: tb/tb_cond_write_back_arbiter.sv
// Scoreboard bench for cond_write_back_arbiter: directed scenarios plus a
// random phase, all checked against a cycle-level reference model.
module tb_cond_write_back_arbiter;
  import ppc_types::*;

  localparam int D = 4;
  localparam int W = 5;

  typedef struct {
    logic [W-1:0]    id;
    cond_exception_t cx;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [0:D-1]              iv  = '0;
  logic [0:D-1]              irdy;
  logic [0:D-1][W-1:0]       rs_in = '0;
  cond_exception_t [0:D-1]   cx_in = '0;
  logic                      ov;
  logic                      oready = 1'b1;
  logic [W-1:0]              rs_out;
  cond_exception_t           cx_out;
  logic                      cwe;
  logic                      xwe;

  int   total = 0;
  int   bad   = 0;
  int   m_prio = 0;
  bit   m_ov   = 1'b0;
  exp_t exp_q[$];

  cond_write_back_arbiter #(.ARBITER_DEPTH(D), .RS_ID_WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .input_valid      (iv),
    .input_ready      (irdy),
    .rs_id_in         (rs_in),
    .cr0_xer_in       (cx_in),
    .output_valid     (ov),
    .output_ready     (oready),
    .rs_id_out        (rs_out),
    .cr0_xer_out      (cx_out),
    .cr0_write_enable (cwe),
    .xer_write_enable (xwe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic cond_exception_t mk_cx(input bit cr0, input bit ca, input bit ovf, input logic [6:0] bits);
    cond_exception_t c;
    c           = cond_exception_t'({bits, 3'b000});
    c.alter_cr0 = cr0;
    c.alter_ca  = ca;
    c.alter_ov  = ovf;
    return c;
  endfunction

  task automatic set_unit(input int u, input bit v, input logic [W-1:0] id, input cond_exception_t c);
    iv[u]    = v;
    rs_in[u] = id;
    cx_in[u] = c;
  endtask

  // One clock: called just after a negedge with inputs settled.
  task automatic cyc(input bit dchk = 1'b0, input logic [0:D-1] drdy = '0);
    int           g;
    bit           gv;
    bit           adv;
    logic [0:D-1] er;
    exp_t         e;
    #1;
    adv = !m_ov || oready;
    gv  = 1'b0;
    g   = 0;
    for (int i = 0; i < D; i++) begin
      int idx;
      idx = (m_prio + i) % D;
      if (!gv && iv[idx]) begin gv = 1'b1; g = idx; end
    end
    er = '0;
    if (adv && gv) er[g] = 1'b1;
    if (dchk) chk("dir_rdy", irdy, drdy);
    chk("rdy", irdy, er);
    chk("ov", ov, m_ov);
    if (m_ov && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("rsid", rs_out, e.id);
      chk("cx", cx_out, e.cx);
      chk("cwe", cwe, oready & e.cx.alter_cr0);
      chk("xwe", xwe, oready & (e.cx.alter_ca | e.cx.alter_ov));
    end else begin
      chk("we_idle", {cwe, xwe}, 0);
    end
    if (m_ov && oready) void'(exp_q.pop_front());
    if (adv) begin
      m_ov = 1'b0;
      if (gv) begin
        m_prio = (g + 1) % D;
        if (cx_in[g].alter_cr0 || cx_in[g].alter_ca || cx_in[g].alter_ov) begin
          e.id = rs_in[g];
          e.cx = cx_in[g];
          exp_q.push_back(e);
          m_ov = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state, with requests already asserted.
    for (int u = 0; u < D; u++) set_unit(u, 1'b1, W'(10 + u), mk_cx(1, 0, 0, 7'h55));
    repeat (2) @(negedge clk);
    chk("rst_ov", ov, 0);
    chk("rst_rsid", rs_out, 0);
    chk("rst_cx", cx_out, 0);
    chk("rst_rdy", irdy, 0);
    chk("rst_we", {cwe, xwe}, 0);
    rst = 1'b1;

    // Full contention: strict 0,1,2,3,0 order, one result per cycle.
    cyc(1, 4'b1000);
    cyc(1, 4'b0100);
    cyc(1, 4'b0010);
    cyc(1, 4'b0001);
    cyc(1, 4'b1000);
    iv = '0;
    cyc();

    // Single XER-only result from unit 2.
    set_unit(2, 1'b1, 5'd9, mk_cx(0, 1, 0, 7'b0000001));
    cyc(1, 4'b0010);
    iv = '0;
    cyc();

    // prio=3: unit 3 first, then wrap to unit 0.
    set_unit(0, 1'b1, 5'd3, mk_cx(0, 0, 1, 7'h21));
    set_unit(3, 1'b1, 5'd7, mk_cx(0, 0, 1, 7'h12));
    cyc(1, 4'b0001);
    cyc(1, 4'b1000);
    iv = '0;

    // Backpressure: hold one result three cycles, then release.
    set_unit(1, 1'b1, 5'd17, mk_cx(1, 0, 0, 7'h7f));
    cyc(1, 4'b0100);
    oready = 1'b0;
    set_unit(3, 1'b1, 5'd30, mk_cx(1, 1, 0, 7'h03));
    cyc(1, 4'b0000);
    cyc(1, 4'b0000);
    cyc(1, 4'b0000);
    oready = 1'b1;
    cyc(1, 4'b0001);
    iv = '0;
    cyc();

    // Nothing altered: consumed, no output, prio still moves past unit 0.
    set_unit(0, 1'b1, 5'd4, mk_cx(0, 0, 0, 7'h7f));
    cyc(1, 4'b1000);
    set_unit(1, 1'b1, 5'd5, mk_cx(1, 0, 0, 7'h00));
    cyc(1, 4'b0100);
    iv = '0;
    cyc();

    // Random traffic with random backpressure.
    for (int n = 0; n < 300; n++) begin
      for (int u = 0; u < D; u++)
        set_unit(u, 1'($urandom_range(0, 1)), W'($urandom), cond_exception_t'($urandom_range(0, 1023)));
      oready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    iv = '0;
    oready = 1'b1;
    cyc();

    // Asynchronous reset while a result is held.
    set_unit(2, 1'b1, 5'd22, mk_cx(1, 1, 1, 7'h11));
    cyc();
    iv = '0;
    oready = 1'b0;
    cyc();
    chk("held_ov", ov, 1);
    oready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ov", ov, 0);
    chk("arst_we", {cwe, xwe}, 0);
    chk("arst_rdy", irdy, 0);
    @(negedge clk);
    rst = 1'b1;
    m_prio = 0;
    m_ov = 1'b0;
    exp_q.delete();
    for (int u = 0; u < D; u++) set_unit(u, 1'b1, W'(u), mk_cx(1, 0, 0, 7'h00));
    cyc(1, 4'b1000);
    cyc(1, 4'b0100);
    iv = '0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
